// File: rtl/riscv_pkg.sv
// Shared constants and FSM encoding for the register file with scoreboard.
package riscv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, x0 never busy.
module regfile_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            set_v,
    input  logic [AW-1:0]   set_idx,
    input  logic            clr_a_v,
    input  logic [AW-1:0]   clr_a_idx,
    input  logic            clr_b_v,
    input  logic [AW-1:0]   clr_b_idx,
    output logic [NREG-1:0] busy
);

    // Flush beats everything; a new issue beats a write-back to the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int r = 1; r < NREG; r++) begin
                if (flush)
                    busy[r] <= 1'b0;
                else if (set_v && set_idx == AW'(r))
                    busy[r] <= 1'b1;
                else if ((clr_a_v && clr_a_idx == AW'(r)) ||
                         (clr_b_v && clr_b_idx == AW'(r)))
                    busy[r] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-read / two-write register file with write-through bypass, pending-write
// scoreboard and a one-register-per-cycle clear sweep.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | normal operation, writes/issues accepted, ready=1
// ST_CLEAR | sweeping registers 1..NREG-1 to zero, inputs ignored
module regfile_sb
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            we_a,
    input  logic [AW-1:0]   wa_a,
    input  logic [XLEN-1:0] wd_a,
    input  logic            we_b,
    input  logic [AW-1:0]   wa_b,
    input  logic [XLEN-1:0] wd_b,
    input  logic            iss_v,
    input  logic [AW-1:0]   iss_rd,
    input  logic            clr_req,
    output logic            ready
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    rf_state_e       state, state_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] sb_busy;
    logic            wr_a, wr_b, flush, issue;

    assign ready = (state == ST_IDLE);
    // Writes to x0 are dropped here so neither storage nor scoreboard sees them.
    assign wr_a  = ready && we_a && (wa_a != '0);
    assign wr_b  = ready && we_b && (wa_b != '0);
    assign issue = ready && iss_v && (iss_rd != '0);
    assign flush = ready && clr_req;

    // State and sweep counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: counter holds at the last index on exit rather than wrapping.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = AW'(1);
                end
            end
            ST_CLEAR: begin
                if (cnt == LAST_IDX)
                    state_nxt = ST_IDLE;
                else
                    cnt_nxt = cnt + AW'(1);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Storage: sweep write in CLEAR, otherwise port A then port B so B wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++)
                mem[r] <= '0;
        end else if (state == ST_CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            if (wr_a)
                mem[wa_a] <= wd_a;
            if (wr_b)
                mem[wa_b] <= wd_b;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .set_v     (issue),
        .set_idx   (iss_rd),
        .clr_a_v   (wr_a),
        .clr_a_idx (wa_a),
        .clr_b_v   (wr_b),
        .clr_b_idx (wa_b),
        .busy      (sb_busy)
    );

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] ra);
        if (ra == '0)
            return '0;
        else if (wr_b && wa_b == ra)
            return wd_b;
        else if (wr_a && wa_a == ra)
            return wd_a;
        else
            return mem[ra];
    endfunction

    function automatic logic busy_port(input logic [AW-1:0] ra);
        return (ra != '0) && sb_busy[ra] &&
               !((wr_a && wa_a == ra) || (wr_b && wa_b == ra));
    endfunction

    // Combinational read ports with bypass and busy masking.
    always_comb begin
        rd1   = read_port(ra1);
        rd2   = read_port(ra2);
        busy1 = busy_port(ra1);
        busy2 = busy_port(ra2);
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREG, default 32, number of architectural registers (power of two, >=4).
REQ-003 Parameter AW, default $clog2(NREG), register address width.
REQ-004 clk  input  1  system clock, the only clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ra1, ra2  input  AW  read addresses.
REQ-007 rd1, rd2  output  XLEN  read data.
REQ-008 busy1, busy2  output  1  scoreboard pending-write flags for ra1/ra2.
REQ-009 we_a, wa_a, wd_a  input  1/AW/XLEN  write port A: enable, address, data.
REQ-010 we_b, wa_b, wd_b  input  1/AW/XLEN  write port B: enable, address, data.
REQ-011 iss_v, iss_rd  input  1/AW  issue strobe; marks iss_rd pending.
REQ-012 clr_req  input  1  request a full register-file clear.
REQ-013 ready  output  1  high when IDLE; writes and issues accepted.

Function
REQ-014 Register 0 SHALL always read 0, ignore writes, and never be marked busy.
REQ-015 Reads SHALL be combinational; storage updates on rising clk.
REQ-016 A read whose address matches an enabled write (A or B) in the same cycle SHALL return the write data (write-through bypass).
REQ-017 When both ports write the same address in one cycle, port B SHALL win for storage and bypass.
REQ-018 busy[r] SHALL be set at the clk edge when ready & iss_v & iss_rd==r, r!=0.
REQ-019 busy[r] SHALL be cleared at the clk edge when ready and either port writes r.
REQ-020 Simultaneous set and clear of the same r SHALL leave busy[r]=1 (new issue wins).
REQ-021 busyN SHALL equal busy[raN] & ~(enabled write to raN this cycle); 0 when raN==0.
REQ-022 FSM states: IDLE, CLEAR; IDLE->CLEAR on clr_req; CLEAR->IDLE after the last register is cleared.
REQ-023 On entering CLEAR, all busy bits SHALL clear; counter loads 1.
REQ-024 In CLEAR, one register per cycle (counter index) SHALL be written 0, counter increments; CLEAR lasts NREG-1 cycles; ready=1 again on the following cycle.
REQ-025 In CLEAR, ready=0, write ports, iss_v and clr_req SHALL be ignored; reads return current storage without bypass.
REQ-026 Counter SHALL not wrap; exit occurs when counter==NREG-1 is cleared.

Reset
REQ-027 rst high SHALL asynchronously set all registers to 0, all busy bits to 0, FSM to IDLE, counter to 0.
REQ-028 During/after reset: rd1=rd2=0, busy1=busy2=0, ready=1.
REQ-029 rst asserted mid-CLEAR SHALL abort the sweep; state after release equals REQ-027.

Structure
REQ-030 FSM state encoding and default XLEN/NREG constants SHALL live in shared package riscv_pkg.
REQ-031 The scoreboard (busy vector, set/clear logic) SHALL be a sub-module regfile_scoreboard; storage, bypass and FSM stay in regfile_sb.

Verification
REQ-032 Write A x5=0xDEADBEEF, next cycle ra1=5 -> rd1=0xDEADBEEF; same-cycle ra2=5 during write -> rd2=0xDEADBEEF.
REQ-033 we_a,we_b both to x7 with 0x1111/0x2222 -> rd1(x7)=0x2222 same cycle and after.
REQ-034 Write x0=0xFFFFFFFF, iss_rd=0 -> rd1(x0)=0, busy1=0.
REQ-035 Issue x3; next cycle busy1(x3)=1; write x3 with iss_rd=3 same cycle -> busy stays 1; write x3 alone -> busy 0.
REQ-036 Fill x1..x31 nonzero, pulse clr_req -> ready=0 for 31 cycles, writes ignored, then all reads 0, busy 0, ready=1.
REQ-037 Assert rst at CLEAR cycle 10 -> all outputs at reset values immediately, ready=1 after release.
